sa_fifo_ctrl_256x14: RTL and testbench
======================================

Name: sa_fifo_ctrl_256x14

Overview:
- Valid/ready FIFO controller that sequences one 256x14 two-port single-clock RAM macro (sa_ram_rwsp_256x14) as a 256-entry queue plus one output-register entry.
- The macro has a registered read address (re) and a registered output (ore), so a read takes two cycles. This block issues re/ore in a pipelined way so the queue sustains one push and one pop per cycle under backpressure.
- Sits between producer and consumer datapaths in the large-config buffer paths, and forwards the RAM power-down bus.

Parameters:
- DEPTH, 256, RAM entries. Only the default is supported.
- AW, 8, RAM address width (log2 DEPTH).
- DW, 14, payload width.

Ports:
- clk  in  1  core clock
- reset_  in  1  async active-low reset
- wr_pvld  in  1  producer valid
- wr_prdy  out  1  producer ready
- wr_pd  in  DW  producer payload
- rd_pvld  out  1  consumer valid
- rd_prdy  in  1  consumer ready
- rd_pd  out  DW  consumer payload (RAM dout)
- fifo_count  out  AW+1  entries held: RAM entries not yet captured plus output entry (0..257)
- fifo_idle  out  1  fifo_count==0 and no read in flight
- pwrbus_ram_pd  in  32  passed unchanged to the RAM

Behaviour:
- State, all reset by reset_:
  - wp and rp: AW-bit pointers, reset 0.
  - ram_cnt: AW+1 bits, reset 0.
  - p1_vld (RAM address stage valid), reset 0.
  - p2_vld (RAM output register valid), reset 0.
- Reset values of outputs: wr_prdy=1, rd_pvld=0, fifo_count=0, fifo_idle=1. rd_pd is don't-care while rd_pvld=0; the RAM datapath is not reset.
- Reset asserted mid-operation discards all contents immediately. No partial transfer completes.
- Write side:
  - wr_prdy = (ram_cnt < DEPTH).
  - push = wr_pvld & wr_prdy drives RAM we=1, wa=wp, di=wr_pd; wp increments.
- Read pipeline:
  - ore = p1_vld & (!p2_vld | rd_prdy).
  - issue = (ram_cnt - p1_vld != 0) & (!p1_vld | ore).
  - RAM re=issue, ra=rp; rp increments on issue.
  - p1_vld next = issue | (p1_vld & !ore).
  - p2_vld next = ore | (p2_vld & !rd_prdy).
- Output side:
  - rd_pvld = p2_vld, rd_pd = RAM dout.
  - pop = rd_pvld & rd_prdy.
  - When ore=0 the RAM output register holds, so rd_pd stays stable while rd_pvld=1 and rd_prdy=0. This is mandatory.
- Slot ownership:
  - A RAM slot is freed at ore, not at issue, because the slot under ra_d must not be overwritten before capture.
  - ram_cnt next = ram_cnt + push - ore.
- Counters:
  - fifo_count = ram_cnt + p2_vld.
  - fifo_idle = (fifo_count==0).
- Latency: a push accepted at edge n gives rd_pvld=1 after edge n+2 when empty and unstalled. Steady state: 1 entry/cycle both sides.
- Boundary conditions:
  - Full: ram_cnt==256 forces wr_prdy=0. A simultaneous ore in that cycle does not raise wr_prdy until the next cycle, so wr_prdy stays purely registered-state based.
  - Simultaneous push and ore at full-1 or empty: the counter arithmetic handles both. A read of the slot just written can issue at the next cycle at the earliest.
  - Pointer wrap: 255→0 by natural AW-bit overflow.
  - Full occupancy with rd_prdy=0: 256 in RAM plus 1 in the output register gives fifo_count=257. p1 holds one of the 256.
- Assertions:
  - No push when wr_prdy=0.
  - ram_cnt ≤ DEPTH.
  - rd_pd stable while rd_pvld & !rd_prdy.

Decomposition:
- Shared package:
  - SA_FIFO_DEPTH=256, SA_FIFO_AW=8, SA_FIFO_DW=14.
  - Count width constant (AW+1).
- One sub-module: sa_ram_rwsp_256x14, instantiated as u_ram. The controller logic stays flat in this module.

Test Plan:
- Reset, then one push of 14'h1A5 at edge 0 with rd_prdy=1 -> rd_pvld rises after edge 2 with rd_pd=14'h1A5; fifo_count reads 1 then 0.
- Continuous push of 0..999 with rd_prdy=1 -> in-order output, one word/cycle after 2-cycle fill, fifo_count ≤ 3, no bubbles.
- rd_prdy=0, push until wr_prdy drops -> exactly 257 pushes accepted, fifo_count=257. Then drain with rd_prdy=1 -> 257 words in order, correct across pointer wrap.
- Random rd_prdy (50%) and wr_pvld (70%) for 10k cycles against a scoreboard queue -> no loss, duplication or reorder; rd_pd stable during every stall.
- Push a word, then assert reset_ low mid-read (p1_vld=1) -> rd_pvld=0, fifo_count=0, wr_prdy=1 immediately. The next push of 14'h3FFF emerges alone after 2 edges.
- At full (257), pulse rd_prdy for 1 cycle with wr_pvld=1 -> one pop, then exactly one push accepted the following cycle, fifo_count returns to 257.

Source files
------------

// File: rtl/sa_fifo_ctrl_256x14_pkg.sv
// sa_fifo_ctrl_256x14_pkg: shared sizes and types for the 256x14 FIFO controller and its RAM macro.
package sa_fifo_ctrl_256x14_pkg;
    localparam int SA_FIFO_DEPTH = 256;
    localparam int SA_FIFO_AW    = 8;
    localparam int SA_FIFO_DW    = 14;
    localparam int SA_FIFO_CW    = SA_FIFO_AW + 1;
    typedef logic [SA_FIFO_CW-1:0] sa_fifo_cnt_t;
    typedef logic [SA_FIFO_AW-1:0] sa_fifo_addr_t;
    typedef logic [SA_FIFO_DW-1:0] sa_fifo_data_t;
endpackage

// File: rtl/sa_fifo_ctrl_256x14_ram.sv
// sa_ram_rwsp_256x14: two-port single-clock RAM with registered read address and registered output.
module sa_ram_rwsp_256x14
    import sa_fifo_ctrl_256x14_pkg::*;
(
    input  logic                  clk,
    input  logic                  re,
    input  logic                  ore,
    input  logic [SA_FIFO_AW-1:0] ra,
    input  logic                  we,
    input  logic [SA_FIFO_AW-1:0] wa,
    input  logic [SA_FIFO_DW-1:0] di,
    output logic [SA_FIFO_DW-1:0] dout,
    input  logic [31:0]           pwrbus_ram_pd
);
    sa_fifo_data_t mem [SA_FIFO_DEPTH];
    sa_fifo_addr_t ra_q;
    sa_fifo_data_t dout_q;
    logic          pwr_unused;

    assign pwr_unused = ^pwrbus_ram_pd;
    assign dout       = dout_q;

    always_ff @(posedge clk) begin
        if (we) mem[wa] <= di;
        if (re) ra_q <= ra;
        if (ore) dout_q <= mem[ra_q];
    end
endmodule

// File: rtl/sa_fifo_ctrl_256x14.sv
// sa_fifo_ctrl_256x14: valid/ready FIFO over a 256x14 two-cycle-read RAM plus one output-register entry.
module sa_fifo_ctrl_256x14
    import sa_fifo_ctrl_256x14_pkg::*;
#(
    parameter int DEPTH = SA_FIFO_DEPTH,
    parameter int AW    = SA_FIFO_AW,
    parameter int DW    = SA_FIFO_DW
)(
    input  logic          clk,
    input  logic          reset_,
    input  logic          wr_pvld,
    output logic          wr_prdy,
    input  logic [DW-1:0] wr_pd,
    output logic          rd_pvld,
    input  logic          rd_prdy,
    output logic [DW-1:0] rd_pd,
    output logic [AW:0]   fifo_count,
    output logic          fifo_idle,
    input  logic [31:0]   pwrbus_ram_pd
);
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [AW:0]   ram_cnt_q, ram_cnt_d;
    logic          p1_vld_q, p1_vld_d, p2_vld_q, p2_vld_d;
    logic          push, ore, issue;

    always_comb begin
        wr_prdy   = ram_cnt_q < (AW+1)'(DEPTH);
        push      = wr_pvld & wr_prdy;
        ore       = p1_vld_q & (~p2_vld_q | rd_prdy);
        // only entries not already sitting in the address stage may be issued
        issue     = (ram_cnt_q - (AW+1)'(p1_vld_q) != '0) & (~p1_vld_q | ore);
        wp_d      = wp_q + AW'(push);
        rp_d      = rp_q + AW'(issue);
        ram_cnt_d = ram_cnt_q + (AW+1)'(push) - (AW+1)'(ore);
        p1_vld_d  = issue | (p1_vld_q & ~ore);
        p2_vld_d  = ore | (p2_vld_q & ~rd_prdy);
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            wp_q      <= '0;
            rp_q      <= '0;
            ram_cnt_q <= '0;
            p1_vld_q  <= 1'b0;
            p2_vld_q  <= 1'b0;
        end else begin
            wp_q      <= wp_d;
            rp_q      <= rp_d;
            ram_cnt_q <= ram_cnt_d;
            p1_vld_q  <= p1_vld_d;
            p2_vld_q  <= p2_vld_d;
        end
    end

    assign rd_pvld    = p2_vld_q;
    assign fifo_count = ram_cnt_q + (AW+1)'(p2_vld_q);
    assign fifo_idle  = fifo_count == '0;

    sa_ram_rwsp_256x14 u_ram (
        .clk           (clk),
        .re            (issue),
        .ore           (ore),
        .ra            (rp_q),
        .we            (push),
        .wa            (wp_q),
        .di            (wr_pd),
        .dout          (rd_pd),
        .pwrbus_ram_pd (pwrbus_ram_pd)
    );

    a_no_push_full: assert property (@(posedge clk) disable iff (!reset_)
        !(push && ram_cnt_q == (AW+1)'(DEPTH)));
    a_cnt_max: assert property (@(posedge clk) disable iff (!reset_)
        ram_cnt_q <= (AW+1)'(DEPTH));
    a_pd_stable: assert property (@(posedge clk) disable iff (!reset_)
        rd_pvld && !rd_prdy |=> $stable(rd_pd));
endmodule

// File: tb/tb_sa_fifo_ctrl_256x14.sv
// tb_sa_fifo_ctrl_256x14: queue-level reference model checked every cycle, plus directed literal checks.
module tb_sa_fifo_ctrl_256x14;
    logic        clk, reset_, wr_pvld, wr_prdy, rd_pvld, rd_prdy, fifo_idle;
    logic [13:0] wr_pd, rd_pd;
    logic [8:0]  fifo_count;
    logic [31:0] pwrbus_ram_pd;

    int          n_chk, n_fail, n_pop, p0, acc;
    logic [13:0] m_q[$];
    logic [13:0] m_word;
    bit          m_vld, m_addr, m_push, m_ore, m_iss;

    sa_fifo_ctrl_256x14 dut (
        .clk           (clk),
        .reset_        (reset_),
        .wr_pvld       (wr_pvld),
        .wr_prdy       (wr_prdy),
        .wr_pd         (wr_pd),
        .rd_pvld       (rd_pvld),
        .rd_prdy       (rd_prdy),
        .rd_pd         (rd_pd),
        .fifo_count    (fifo_count),
        .fifo_idle     (fifo_idle),
        .pwrbus_ram_pd (pwrbus_ram_pd)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Model: m_q holds words in the RAM (not yet captured), m_addr marks that its head is
    // already addressed, m_vld/m_word is the output register.
    initial forever begin
        @(posedge clk or negedge reset_);
        if (!reset_) begin
            m_q.delete();
            m_addr = 0;
            m_vld  = 0;
        end else begin
            if (m_vld && rd_prdy) n_pop++;
            m_push = wr_pvld && m_q.size() < 256;
            m_ore  = m_addr && (!m_vld || rd_prdy);
            m_iss  = (m_q.size() - int'(m_addr) > 0) && (!m_addr || m_ore);
            if (m_ore) begin
                m_word = m_q.pop_front();
                m_vld  = 1;
            end else if (rd_prdy) m_vld = 0;
            m_addr = m_iss || (m_addr && !m_ore);
            if (m_push) m_q.push_back(wr_pd);
        end
    end

    initial forever begin
        @(negedge clk);
        chk("wr_prdy", wr_prdy, int'(m_q.size() < 256));
        chk("rd_pvld", rd_pvld, m_vld);
        chk("fifo_count", fifo_count, m_q.size() + int'(m_vld));
        chk("fifo_idle", fifo_idle, int'(m_q.size() + int'(m_vld) == 0));
        if (m_vld) chk("rd_pd", rd_pd, m_word);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not complete");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1, "watchdog");
    end

    task automatic drain(string name, int exp_pops);
        @(negedge clk);
        wr_pvld = 0;
        rd_prdy = 1;
        for (int i = 0; i < 600 && !fifo_idle; i++) @(negedge clk);
        chk({name, "_idle"}, fifo_idle, 1);
        if (exp_pops >= 0) chk({name, "_pops"}, n_pop - p0, exp_pops);
    endtask

    initial begin
        clk = 0; reset_ = 1; wr_pvld = 0; wr_pd = '0; rd_prdy = 0; pwrbus_ram_pd = 32'h0;
        #1 reset_ = 0;
        repeat (2) @(negedge clk);
        chk("rst_prdy", wr_prdy, 1);
        chk("rst_pvld", rd_pvld, 0);
        chk("rst_cnt", fifo_count, 0);
        chk("rst_idle", fifo_idle, 1);
        @(posedge clk); #2 reset_ = 1;

        // single word latency
        @(negedge clk); wr_pvld = 1; wr_pd = 14'h1A5; rd_prdy = 1;
        @(negedge clk); wr_pvld = 0;
        chk("t1_cnt_e0", fifo_count, 1);
        chk("t1_vld_e0", rd_pvld, 0);
        @(negedge clk); chk("t1_vld_e1", rd_pvld, 0);
        @(negedge clk);
        chk("t1_vld_e2", rd_pvld, 1);
        chk("t1_pd", rd_pd, 14'h1A5);
        chk("t1_cnt_e2", fifo_count, 1);
        @(negedge clk);
        chk("t1_vld_e3", rd_pvld, 0);
        chk("t1_cnt_e3", fifo_count, 0);

        // streaming 0..999 with no backpressure
        p0 = n_pop;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            chk("t2_cnt_le3", int'(fifo_count <= 3), 1);
            wr_pvld = 1; wr_pd = 14'(i);
        end
        @(negedge clk); wr_pvld = 0;
        repeat (3) @(negedge clk);
        chk("t2_pops", n_pop - p0, 1000);
        chk("t2_idle", fifo_idle, 1);

        // fill with consumer stalled
        acc = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!wr_prdy) break;
            wr_pvld = 1; rd_prdy = 0; wr_pd = 14'h2000 + 14'(acc); acc++;
        end
        chk("t3_accepted", acc, 257);
        chk("t3_cnt_full", fifo_count, 257);
        chk("t3_vld_full", rd_pvld, 1);
        chk("t3_pd_head", rd_pd, 14'h2000);

        // one pop at full with producer waiting
        chk("t6_prdy_a", wr_prdy, 0);
        rd_prdy = 1; wr_pd = 14'h2000 + 14'(acc);
        @(negedge clk);
        chk("t6_prdy_b", wr_prdy, 1);
        chk("t6_cnt_b", fifo_count, 256);
        chk("t6_pd_b", rd_pd, 14'h2001);
        rd_prdy = 0;
        @(negedge clk);
        chk("t6_prdy_c", wr_prdy, 0);
        chk("t6_cnt_c", fifo_count, 257);
        wr_pvld = 0;
        p0 = n_pop;
        drain("t3_drain", 257);

        // randomized traffic
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            wr_pvld = $urandom_range(0, 9) < 7;
            wr_pd   = 14'($urandom);
            rd_prdy = $urandom_range(0, 1) == 1;
        end
        drain("t4_drain", -1);

        // reset while a read is in flight
        @(negedge clk); wr_pvld = 1; wr_pd = 14'h1234; rd_prdy = 1;
        @(negedge clk); wr_pvld = 0;
        @(posedge clk); #1;
        chk("t5_cnt_pre", fifo_count, 1);
        reset_ = 0;
        #1;
        chk("t5_pvld", rd_pvld, 0);
        chk("t5_cnt", fifo_count, 0);
        chk("t5_prdy", wr_prdy, 1);
        chk("t5_idle", fifo_idle, 1);
        @(posedge clk); #2 reset_ = 1;
        @(negedge clk); wr_pvld = 1; wr_pd = 14'h3FFF; rd_prdy = 1;
        @(negedge clk); wr_pvld = 0; chk("t5_vld_e0", rd_pvld, 0);
        @(negedge clk); chk("t5_vld_e1", rd_pvld, 0);
        @(negedge clk);
        chk("t5_vld_e2", rd_pvld, 1);
        chk("t5_pd", rd_pd, 14'h3FFF);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t5_alone", rd_pvld, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
